// File: rtl/shift_register_6bit_transmitter_if.sv
// Handshake and serial-status bundle for the 6-bit PISO transmitter.
// master: the word source / link observer. slave: the transmitter itself.
interface shift_register_6bit_transmitter_if #(
    parameter int WIDTH = 6
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             stall;
    logic             ready;
    logic             serialOutput;
    logic             busy;
    logic             frameDone;
    logic [2:0]       bitCount;

    modport master (
        output load, data, stall,
        input  ready, serialOutput, busy, frameDone, bitCount
    );

    modport slave (
        input  load, data, stall,
        output ready, serialOutput, busy, frameDone, bitCount
    );
endinterface

// File: rtl/shift_register_6bit_transmitter.sv
// Parallel-in, serial-out 6-bit transmitter, LSB first, one bit per clock.
// Optional feature macro: SHIFTREGISTER_PARITY_EN appends an even-parity
// 7th bit (XOR of the accepted word) and moves the last-bit cycle to it.
// Only WIDTH = 6 is supported; bitCount is 3 bits wide to cover index 6.
module shift_register_6bit_transmitter #(
    parameter int WIDTH = 6
) (
    input  logic                            clockpulse,
    input  logic                            clear,
    shift_register_6bit_transmitter_if.slave bus
);

`ifdef SHIFTREGISTER_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int RW = LAST + 1;   // frame bits held in the shift register

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] sreg;
    logic [2:0]    cnt;
    logic [RW-1:0] frame_word;
    logic          last_bit;
    logic          ready_i;
    logic          accept;
    logic          advance;

    // Word as it will be framed; parity rides above the data MSB so the
    // same right shift delivers it after bit 5.
`ifdef SHIFTREGISTER_PARITY_EN
    assign frame_word = {^bus.data, bus.data};
`else
    assign frame_word = bus.data;
`endif

    // Handshake decode: the ready window is IDLE or an unstalled last bit.
    always_comb begin
        last_bit = (state == SHIFT) && (cnt == 3'(LAST));
        ready_i  = (state == IDLE) || (last_bit && !bus.stall);
        accept   = bus.load && ready_i;
        advance  = (state == SHIFT) && !bus.stall && !last_bit;
    end

    // State register.
    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: a frame ends at the unstalled last bit unless a new word
    // is accepted on the same edge, which keeps the link streaming.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !bus.stall) state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state; ready/frameDone also see stall.
    always_comb begin
        bus.busy         = (state == SHIFT);
        bus.serialOutput = (state == SHIFT) ? sreg[0] : 1'b0;
        bus.ready        = ready_i;
        bus.frameDone    = last_bit && !bus.stall;
        bus.bitCount     = cnt;
    end

    // Datapath: load on acceptance, otherwise shift right with zero fill.
    // bitCount saturates at LAST and only returns to 0 on acceptance.
    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= frame_word;
            cnt  <= '0;
        end else if (advance) begin
            sreg <= {1'b0, sreg[RW-1:1]};
            cnt  <= cnt + 3'd1;
        end
    end

endmodule
